// File: rtl/fir_sample_scheduler.sv
// Sample feeder for the time-shared FIR: buffers bursty input in a FIFO and issues one
// sample per FRAME_LEN-cycle frame. Optional macro FIR_SCHED_HOLD_LAST_EN repeats the last sample on underrun.
module fir_sample_scheduler #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAME_LEN  = 20,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PREFILL    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_W-1:0]               s_data,
    output logic [DATA_W-1:0]               fir_data,
    output logic                            fir_strobe,
    output logic [$clog2(FRAME_LEN)-1:0]    frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underrun,
    output logic [7:0]                      underrun_cnt
);

    localparam int unsigned CntW = $clog2(FRAME_LEN);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic {StFill, StRun} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic              push;
    logic              pop;
    logic              slot;
    logic              starved;

    // s_ready depends only on the registered level, so no combinational path from s_valid.
    assign s_ready = (fifo_level != LvlW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign slot    = (state == StRun) && (frame_cnt == CntW'(FRAME_LEN - 1));
    assign pop     = slot && (fifo_level != '0);
    assign starved = slot && (fifo_level == '0);

    // Storage needs no reset: pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StFill;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            frame_cnt    <= '0;
            fir_data     <= '0;
            fir_strobe   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= fifo_level + LvlW'(push) - LvlW'(pop);
            fir_strobe <= slot;

            unique case (state)
                StFill: begin
                    frame_cnt <= '0;
                    if (fifo_level >= LvlW'(PREFILL)) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    frame_cnt <= slot ? '0 : frame_cnt + 1'b1;
                end
                default: state <= StFill;
            endcase

            if (pop) begin
                fir_data <= mem[rd_ptr];
            end else if (starved) begin
`ifdef FIR_SCHED_HOLD_LAST_EN
                fir_data <= fir_data;
`else
                fir_data <= '0;
`endif
                underrun <= 1'b1;
                if (underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_scheduler.sv
// Bench for fir_sample_scheduler: queue-based reference model compared every cycle,
// plus directed startup, underrun, saturation, mid-run reset, backpressure and hold-last cases.
module tb_fir_sample_scheduler;

    localparam int DATA_W     = 16;
    localparam int FRAME_LEN  = 20;
    localparam int FIFO_DEPTH = 8;
    localparam int PREFILL    = 2;
`ifdef FIR_SCHED_HOLD_LAST_EN
    localparam bit HoldLast = 1'b1;
`else
    localparam bit HoldLast = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic [DATA_W-1:0] fir_data;
    logic              fir_strobe;
    logic [4:0]        frame_cnt;
    logic [3:0]        fifo_level;
    logic              underrun;
    logic [7:0]        underrun_cnt;

    fir_sample_scheduler #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH), .PREFILL(PREFILL)
    ) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_data(fir_data), .fir_strobe(fir_strobe), .frame_cnt(frame_cnt),
        .fifo_level(fifo_level), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a queue of accepted samples, a run flag and a frame position.
    logic [DATA_W-1:0] q[$];
    bit                m_run;
    int                m_pos;
    bit                m_strobe;
    logic [DATA_W-1:0] m_data;
    bit                m_uflag;
    int                m_ucnt;

    always @(posedge clk) begin
        int n;
        bit at_slot;
        n       = q.size();
        at_slot = m_run && (m_pos == FRAME_LEN - 1);
        if (reset) begin
            q.delete();
            m_run = 0; m_pos = 0; m_strobe = 0; m_data = '0; m_uflag = 0; m_ucnt = 0;
        end else begin
            m_strobe = at_slot;
            if (at_slot) begin
                if (n > 0) m_data = q.pop_front();
                else begin
                    if (!HoldLast) m_data = '0;
                    m_uflag = 1;
                    if (m_ucnt < 255) m_ucnt++;
                end
            end
            if (m_run) m_pos = (m_pos + 1) % FRAME_LEN;
            else if (n >= PREFILL) begin
                m_run = 1;
                m_pos = 0;
            end
            if (s_valid && n < FIFO_DEPTH) q.push_back(s_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("s_ready", s_ready, q.size() < FIFO_DEPTH);
            check("fifo_level", fifo_level, q.size());
            check("frame_cnt", frame_cnt, m_pos);
            check("fir_strobe", fir_strobe, m_strobe);
            check("fir_data", fir_data, m_data);
            check("underrun", underrun, m_uflag);
            check("underrun_cnt", underrun_cnt, m_ucnt);
        end
    end

    task automatic wait_strobe(output int at);
        at = -1;
        for (int i = 0; i < FRAME_LEN * 3; i++) begin
            @(posedge clk); #1;
            if (fir_strobe) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("strobe_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int t_push2, t1, t2, t3, t;
        int n, acc, c0;
        bit rdy, saw_full, first;
        logic [DATA_W-1:0] got[$];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("reset_level", fifo_level, 0);
        check("reset_strobe", fir_strobe, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", s_ready, 1);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_fir_data", fir_data, 0);
        check("reset_underrun_cnt", underrun_cnt, 0);

        // Prefill and startup, then underrun on the third strobe
        @(negedge clk); s_valid = 1'b1; s_data = 16'h0011;
        @(negedge clk); s_data = 16'h0022;
        @(posedge clk); #1; t_push2 = cyc;
        @(negedge clk); s_valid = 1'b0;
        wait_strobe(t1);
        check("first_strobe_delay", t1 - t_push2, 21);
        check("first_data", fir_data, 16'h0011);
        wait_strobe(t2);
        check("strobe_period_1", t2 - t1, 20);
        check("second_data", fir_data, 16'h0022);
        check("no_underrun_yet", underrun, 0);
        wait_strobe(t3);
        check("strobe_period_2", t3 - t2, 20);
        check("underrun_data", fir_data, HoldLast ? 16'h0022 : 16'h0000);
        check("underrun_flag", underrun, 1);
        check("underrun_cnt_1", underrun_cnt, 1);
        wait_strobe(t);
        check("underrun_period", t - t3, 20);
        check("underrun_cnt_2", underrun_cnt, 2);

        // Saturation
        repeat (300 * FRAME_LEN) @(posedge clk);
        #1;
        check("underrun_cnt_sat", underrun_cnt, 255);
        check("underrun_sticky", underrun, 1);

        // Reset mid-operation with 5 buffered samples at frame_cnt 12
        wait_strobe(t);
        @(negedge clk); s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 16'h0100 + 16'(i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (frame_cnt == 12) break;
        end
        check("pre_reset_level", fifo_level, 5);
        check("pre_reset_frame_cnt", frame_cnt, 12);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_level", fifo_level, 0);
        check("mid_reset_frame_cnt", frame_cnt, 0);
        check("mid_reset_strobe", fir_strobe, 0);
        check("mid_reset_data", fir_data, 0);
        check("mid_reset_underrun", underrun, 0);
        check("mid_reset_underrun_cnt", underrun_cnt, 0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fill_holds_frame_cnt", frame_cnt, 0);

        // Backpressure: stream 1..10 with s_valid held
        n = 1; acc = 0; saw_full = 0; first = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (n > 10) begin
                s_valid = 1'b0;
                break;
            end
            s_valid = 1'b1;
            s_data  = 16'(n);
            rdy     = s_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc++;
                n++;
            end
            if (fifo_level == FIFO_DEPTH && !saw_full) begin
                saw_full = 1;
                check("ready_low_when_full", s_ready, 0);
            end
            if (fir_strobe) begin
                if (!first) begin
                    first = 1;
                    check("accepted_before_pop", acc, 8);
                    check("ready_after_pop", s_ready, 1);
                end
                got.push_back(fir_data);
            end
        end
        s_valid = 1'b0;
        check("all_ten_accepted", n, 11);
        check("saw_full", saw_full, 1);
        while (got.size() < 10) begin
            wait_strobe(t);
            if (t < 0) break;
            got.push_back(fir_data);
        end
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) check("order", got[i], i + 1);
            else check("order_missing", 0, 1);
        end

        // Starved after one full-scale sample
        @(negedge clk); s_valid = 1'b1; s_data = 16'h7FFF;
        @(negedge clk); s_valid = 1'b0;
        wait_strobe(t);
        check("max_sample", fir_data, 16'h7FFF);
        c0 = underrun_cnt;
        for (int k = 1; k <= 3; k++) begin
            wait_strobe(t);
            check("starve_data", fir_data, HoldLast ? 16'h7FFF : 16'h0000);
            check("starve_cnt", underrun_cnt, c0 + k);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
